// File: rtl/dmem_port_arbiter.sv
// Single-port data memory arbiter between the CPU MEM stage (C) and an external master (E).
// Optional stall cycle counter port stall_cnt_o enabled by defining DMEM_ARB_STALL_CNT_EN.
module dmem_port_arbiter #(
    parameter int RD_LAT   = 2,
    parameter int MAX_WAIT = 4,
    parameter int ADR_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cpu_req_i,
    input  logic             cpu_we_i,
    input  logic [ADR_W-1:0] cpu_adr_i,
    input  logic [31:0]      cpu_wd_i,
    input  logic [1:0]       cpu_sel_i,
    output logic [31:0]      cpu_rd_o,
    output logic             cpu_stall_o,
    input  logic             ext_req_i,
    input  logic             ext_we_i,
    input  logic [ADR_W-1:0] ext_adr_i,
    input  logic [31:0]      ext_wd_i,
    output logic             ext_gnt_o,
    output logic [31:0]      ext_rd_o,
    output logic             ext_rvalid_o,
    output logic             mem_en_o,
    output logic             mem_we_o,
    output logic [ADR_W-1:0] mem_adr_o,
    output logic [31:0]      mem_wd_o,
    output logic [1:0]       mem_sel_o,
    input  logic [31:0]      mem_rd_i
`ifdef DMEM_ARB_STALL_CNT_EN
    ,
    output logic [31:0]      stall_cnt_o
`endif
);

    typedef enum logic [1:0] {IDLE, BUSY_C, BUSY_E} state_t;

    state_t      state_q, state_d;
    logic [2:0]  lat_q, lat_d;
    logic [3:0]  starve_q, starve_d;
    logic [31:0] cpu_rd_q, ext_rd_q;

    logic arb_idle, e_prio, issue_c, issue_e, done, done_c, done_e;

    // Arbitration only happens in IDLE; reset suppresses every issue and completion.
    always_comb begin
        arb_idle = (state_q == IDLE) && !rst_i;
        e_prio   = (starve_q == 4'(MAX_WAIT));
        issue_c  = arb_idle && cpu_req_i && (!ext_req_i || !e_prio);
        issue_e  = arb_idle && ext_req_i && !issue_c;
        done     = (lat_q == 3'd1) && !rst_i;
        done_c   = (state_q == BUSY_C) && done;
        done_e   = (state_q == BUSY_E) && done;
    end

    always_comb begin
        mem_en_o  = issue_c || issue_e;
        mem_we_o  = 1'b0;
        mem_adr_o = '0;
        mem_wd_o  = '0;
        mem_sel_o = 2'b00;
        if (issue_c) begin
            mem_we_o  = cpu_we_i;
            mem_adr_o = cpu_adr_i;
            mem_wd_o  = cpu_wd_i;
            mem_sel_o = cpu_sel_i;
        end else if (issue_e) begin
            mem_we_o  = ext_we_i;
            mem_adr_o = ext_adr_i;
            mem_wd_o  = ext_wd_i;
        end
    end

    // Load data bypasses in the completion cycle so the pipeline sees it as stall drops.
    always_comb begin
        ext_gnt_o    = issue_e;
        ext_rvalid_o = done_e;
        ext_rd_o     = done_e ? mem_rd_i : ext_rd_q;
        cpu_rd_o     = done_c ? mem_rd_i : cpu_rd_q;
        cpu_stall_o  = !rst_i && cpu_req_i &&
                       ((state_q == BUSY_E) || issue_e || (issue_c && !cpu_we_i) ||
                        ((state_q == BUSY_C) && !done));
    end

    always_comb begin
        state_d  = state_q;
        lat_d    = lat_q;
        starve_d = starve_q;
        case (state_q)
            IDLE: begin
                if (issue_c && !cpu_we_i) begin
                    state_d = BUSY_C;
                    lat_d   = 3'(RD_LAT);
                end else if (issue_e && !ext_we_i) begin
                    state_d = BUSY_E;
                    lat_d   = 3'(RD_LAT);
                end
            end
            BUSY_C, BUSY_E: begin
                lat_d = lat_q - 3'd1;
                if (lat_q == 3'd1) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (issue_e)
            starve_d = 4'd0;
        else if (ext_req_i && (starve_q != 4'(MAX_WAIT)))
            starve_d = starve_q + 4'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            lat_q    <= 3'd0;
            starve_q <= 4'd0;
            cpu_rd_q <= 32'd0;
            ext_rd_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            lat_q    <= lat_d;
            starve_q <= starve_d;
            if (done_c) cpu_rd_q <= mem_rd_i;
            if (done_e) ext_rd_q <= mem_rd_i;
        end
    end

`ifdef DMEM_ARB_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i)            stall_cnt_q <= 32'd0;
        else if (cpu_stall_o) stall_cnt_q <= stall_cnt_q + 32'd1;
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter (RD_LAT=2, MAX_WAIT=4) with a small memory model.
module tb_dmem_port_arbiter;
    localparam int RD_LAT = 2;
    localparam int ADR_W  = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             cpu_req, cpu_we, ext_req, ext_we;
    logic [ADR_W-1:0] cpu_adr, ext_adr;
    logic [31:0]      cpu_wd, ext_wd;
    logic [1:0]       cpu_sel;
    logic [31:0]      cpu_rd, ext_rd, mem_wd, mem_rd;
    logic             cpu_stall, ext_gnt, ext_rvalid, mem_en, mem_we;
    logic [ADR_W-1:0] mem_adr;
    logic [1:0]       mem_sel;
`ifdef DMEM_ARB_STALL_CNT_EN
    logic [31:0]      stall_cnt;
`endif

    int errs   = 0;
    int checks = 0;
    int en_cnt = 0;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.RD_LAT(RD_LAT), .MAX_WAIT(4), .ADR_W(ADR_W)) dut (
        .clk_i(clk), .rst_i(rst),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_adr_i(cpu_adr), .cpu_wd_i(cpu_wd),
        .cpu_sel_i(cpu_sel), .cpu_rd_o(cpu_rd), .cpu_stall_o(cpu_stall),
        .ext_req_i(ext_req), .ext_we_i(ext_we), .ext_adr_i(ext_adr), .ext_wd_i(ext_wd),
        .ext_gnt_o(ext_gnt), .ext_rd_o(ext_rd), .ext_rvalid_o(ext_rvalid),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_adr_o(mem_adr), .mem_wd_o(mem_wd),
        .mem_sel_o(mem_sel), .mem_rd_i(mem_rd)
`ifdef DMEM_ARB_STALL_CNT_EN
        , .stall_cnt_o(stall_cnt)
`endif
    );

    // Memory model: word array, read data appears RD_LAT cycles after the issue cycle.
    logic [31:0] mem [0:255];
    logic [31:0] rd_pipe [1:4];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
            mem[4] <= 32'hDEADBEEF;
        end else if (mem_en && mem_we) begin
            mem[mem_adr[9:2]] <= mem_wd;
        end
        rd_pipe[1] <= (mem_en && !mem_we) ? mem[mem_adr[9:2]] : 32'd0;
        for (int k = 2; k <= 4; k++) rd_pipe[k] <= rd_pipe[k-1];
        if (mem_en) en_cnt <= en_cnt + 1;
    end

    assign mem_rd = rd_pipe[RD_LAT];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %08h want %08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        cpu_req = 0; cpu_we = 0; cpu_adr = '0; cpu_wd = '0; cpu_sel = 2'b00;
        ext_req = 0; ext_we = 0; ext_adr = '0; ext_wd = '0;
    endtask

    task automatic do_reset();
        rst = 1;
        idle_in();
        tick(); tick();
        rst = 0;
    endtask

    logic [11:0] v_en, v_stall, v_gnt, v_rv;
    int          en0;

    initial begin
        for (int k = 1; k <= 4; k++) rd_pipe[k] = 32'd0;
        rst = 1;
        idle_in();
        cpu_req = 1; ext_req = 1;
        tick();
        @(negedge clk);
        chk("rst_gnt", ext_gnt, 0);
        chk("rst_stall", cpu_stall, 0);
        chk("rst_en", mem_en, 0);
        chk("rst_cpu_rd", cpu_rd, 0);
        chk("rst_ext_rd", ext_rd, 0);
        tick();
        idle_in();
        rst = 0;
        tick();

        // C load alone
        en0 = en_cnt;
        cpu_req = 1; cpu_adr = 16'h0010;
        @(negedge clk);
        chk("c0_en", mem_en, 1);
        chk("c0_adr", mem_adr, 32'h10);
        chk("c0_stall", cpu_stall, 1);
        tick(); @(negedge clk);
        chk("c1_en", mem_en, 0);
        chk("c1_stall", cpu_stall, 1);
        tick(); @(negedge clk);
        chk("c2_stall", cpu_stall, 0);
        chk("c2_rd", cpu_rd, 32'hDEADBEEF);
        tick(); cpu_req = 0; @(negedge clk);
        chk("c3_rd", cpu_rd, 32'hDEADBEEF);
        chk("c_en_pulses", en_cnt - en0, 1);

        // C store and E load in the same cycle
        cpu_req = 1; cpu_we = 1; cpu_adr = 16'h0020; cpu_wd = 32'h11112222;
        ext_req = 1; ext_adr = 16'h0010;
        @(negedge clk);
        chk("s0_we", mem_we, 1);
        chk("s0_stall", cpu_stall, 0);
        chk("s0_gnt", ext_gnt, 0);
        tick(); cpu_req = 0; cpu_we = 0; @(negedge clk);
        chk("s1_gnt", ext_gnt, 1);
        chk("s1_we", mem_we, 0);
        chk("s1_adr", mem_adr, 32'h10);
        tick(); ext_req = 0; @(negedge clk);
        chk("s2_rv", ext_rvalid, 0);
        tick(); @(negedge clk);
        chk("s3_rv", ext_rvalid, 1);
        chk("s3_rd", ext_rd, 32'hDEADBEEF);

        // Back-to-back C loads with E held: starve saturates, E wins at cycle 6
        tick();
        v_en = 12'h249; v_stall = 12'h7DB; v_gnt = 12'h040; v_rv = 12'h100;
        cpu_req = 1; cpu_adr = 16'h0010; ext_req = 1; ext_adr = 16'h0020;
        for (int c = 0; c < 12; c++) begin
            if (c == 7) ext_req = 0;
            @(negedge clk);
            chk($sformatf("b%0d_en", c), mem_en, v_en[c]);
            chk($sformatf("b%0d_stall", c), cpu_stall, v_stall[c]);
            chk($sformatf("b%0d_gnt", c), ext_gnt, v_gnt[c]);
            chk($sformatf("b%0d_rv", c), ext_rvalid, v_rv[c]);
            if (c == 8) chk("b8_rd", ext_rd, 32'h11112222);
            tick();
        end
        cpu_req = 0;
        tick();

        // E load first, C load one cycle later
        v_en = 12'h009; v_stall = 12'h01E; v_rv = 12'h004;
        ext_req = 1; ext_adr = 16'h0020; cpu_adr = 16'h0010;
        for (int c = 0; c < 6; c++) begin
            if (c == 1) begin ext_req = 0; cpu_req = 1; end
            @(negedge clk);
            chk($sformatf("x%0d_en", c), mem_en, v_en[c]);
            chk($sformatf("x%0d_stall", c), cpu_stall, v_stall[c]);
            chk($sformatf("x%0d_rv", c), ext_rvalid, v_rv[c]);
            if (c == 0) chk("x0_gnt", ext_gnt, 1);
            if (c == 5) chk("x5_rd", cpu_rd, 32'hDEADBEEF);
            tick();
        end
        cpu_req = 0;
        tick();

        // Reset in the middle of an E load
        ext_req = 1; ext_adr = 16'h0010;
        @(negedge clk);
        chk("r0_gnt", ext_gnt, 1);
        tick(); ext_req = 0; rst = 1; @(negedge clk);
        chk("r1_en", mem_en, 0);
        chk("r1_rv", ext_rvalid, 0);
        chk("r1_stall", cpu_stall, 0);
        tick(); rst = 0;
        for (int c = 2; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("r%0d_rv", c), ext_rvalid, 0);
            chk($sformatf("r%0d_en", c), mem_en, 0);
            chk($sformatf("r%0d_rd", c), ext_rd, 0);
            tick();
        end

        // E store: granted, no rvalid
        ext_req = 1; ext_we = 1; ext_adr = 16'h0030; ext_wd = 32'hCAFE0001;
        @(negedge clk);
        chk("w0_gnt", ext_gnt, 1);
        chk("w0_we", mem_we, 1);
        chk("w0_sel", mem_sel, 0);
        tick(); ext_req = 0; ext_we = 0;
        for (int c = 1; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("w%0d_rv", c), ext_rvalid, 0);
            tick();
        end

`ifdef DMEM_ARB_STALL_CNT_EN
        do_reset();
        cpu_req = 1; cpu_adr = 16'h0010;
        for (int c = 0; c < 9; c++) tick();
        cpu_req = 0;
        tick();
        @(negedge clk);
        chk("stall_cnt", stall_cnt, 6);
`else
        do_reset();
`endif
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
